// File: rtl/flappy_pkg.sv
// Shared constants, types and helpers for the flappy game controller.
// Screen geometry, state encoding and the default tube spacing live here
// so the controller, tube scroller and bench agree on them.
package flappy_pkg;

    localparam int SCREEN_W       = 640;
    localparam int SCREEN_H       = 480;
    localparam int BIRD_SIZE      = 25;
    localparam int SCREEN_FLOOR_Y = SCREEN_H - BIRD_SIZE;
    localparam int TUBE_GAP_DEF   = 240;

    localparam int X_W     = 10;
    localparam int VEL_W   = 6;
    localparam int SCORE_W = 8;

    typedef logic [X_W-1:0]            coord_t;
    typedef logic signed [VEL_W-1:0]   vel_t;
    typedef logic [SCORE_W-1:0]        score_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2
    } game_state_t;

    // Adds up to three wrap events to the score, sticking at the maximum.
    function automatic score_t score_sat_add(input score_t s, input logic [1:0] n);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + {{(SCORE_W - 1){1'b0}}, n};
        if (sum[SCORE_W]) begin
            return {SCORE_W{1'b1}};
        end else begin
            return sum[SCORE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/flappy_game_ctrl_if.sv
// Bundle of the per-frame control inputs and the world-coordinate outputs
// exchanged between the game controller and its surroundings.
// master: the side that drives tick/flap/loose (timing, button, decoder).
// slave : the game controller itself.
interface flappy_game_ctrl_if;
    import flappy_pkg::*;

    logic   frame_tick;
    logic   flap;
    logic   loose;
    coord_t posX_tube1;
    coord_t posX_tube2;
    coord_t posX_tube3;
    coord_t pos_y_bird;
    logic   playing;
    logic   game_over;
    score_t score;

    modport master (
        output frame_tick, flap, loose,
        input  posX_tube1, posX_tube2, posX_tube3, pos_y_bird,
        input  playing, game_over, score
    );

    modport slave (
        input  frame_tick, flap, loose,
        output posX_tube1, posX_tube2, posX_tube3, pos_y_bird,
        output playing, game_over, score
    );

endinterface

// File: rtl/tube_scroller.sv
// One tube's X position: steps left by SPEED per enabled frame and wraps
// back by SPAN - SPEED when it would leave the screen, so the spacing
// between tubes is preserved across wraps.
// Optional build macro FLAPPY_SCORE_EN adds the o_wrapped pulse port,
// high during the cycle whose step performs a wrap.
module tube_scroller
    import flappy_pkg::*;
#(
    parameter int X0    = 400,
    parameter int SPEED = 2,
    parameter int SPAN  = 3 * TUBE_GAP_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_step,
    input  logic   i_load,
    output coord_t o_x
`ifdef FLAPPY_SCORE_EN
    ,
    output logic   o_wrapped
`endif
);

    localparam coord_t L_X0       = coord_t'(X0);
    localparam coord_t L_SPEED    = coord_t'(SPEED);
    localparam coord_t L_WRAP_ADD = coord_t'(SPAN - SPEED);

    coord_t r_x;
    coord_t w_x_next;
    logic   w_at_edge;

    assign w_at_edge = (r_x < L_SPEED);

    // Next position: plain step left, or wrap to the far end of the span.
    always_comb begin
        w_x_next = r_x - L_SPEED;
        if (w_at_edge) begin
            w_x_next = r_x + L_WRAP_ADD;
        end else begin
            w_x_next = r_x - L_SPEED;
        end
    end

    // Position register: reset/reload to the start X, otherwise step on enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x <= L_X0;
        end else if (i_load) begin
            r_x <= L_X0;
        end else if (i_step) begin
            r_x <= w_x_next;
        end else begin
            r_x <= r_x;
        end
    end

    assign o_x = r_x;

`ifdef FLAPPY_SCORE_EN
    assign o_wrapped = i_step & w_at_edge;
`endif

endmodule

// File: rtl/flappy_game_ctrl.sv
// Game-state controller: bird physics, tube scrolling, collision handling
// and the IDLE/PLAY/DEAD flow, stepped once per frame_tick.
// Optional build macro FLAPPY_SCORE_EN builds the saturating score counter;
// without it the score output is tied to zero.
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int TUBE_SPEED = 2,
    parameter int TUBE_X0    = 400,
    parameter int TUBE_GAP   = TUBE_GAP_DEF,
    parameter int BIRD_Y0    = 200,
    parameter int FLOOR_Y    = SCREEN_FLOOR_Y,
    parameter int GRAVITY    = 1,
    parameter int VEL_MAX    = 10,
    parameter int FLAP_VEL   = -8,
    parameter int DEAD_HOLD  = 30
) (
    input logic                clk,
    input logic                reset,
    flappy_game_ctrl_if.slave  bus
);

    localparam coord_t             L_BIRD_Y0   = coord_t'(BIRD_Y0);
    localparam coord_t             L_FLOOR_Y   = coord_t'(FLOOR_Y);
    localparam logic [X_W:0]       L_FLOOR_Y11 = (X_W + 1)'(FLOOR_Y);
    localparam vel_t               L_FLAP_VEL  = vel_t'(FLAP_VEL);
    localparam logic signed [VEL_W:0] L_VEL_MAX7 = (VEL_W + 1)'(VEL_MAX);
    localparam logic [7:0]         L_DEAD_HOLD = 8'(DEAD_HOLD);

    game_state_t r_state;
    coord_t      r_y;
    vel_t        r_vel;
    logic        r_pend;
    logic        r_flap_q;
    logic        r_flap_edge;
    logic [7:0]  r_dead_cnt;
    logic        r_playing;
    logic        r_game_over;

    logic [X_W:0]            w_y_sum;
    logic                    w_y_neg;
    logic                    w_y_floor;
    coord_t                  w_y_next;
    logic signed [VEL_W:0]   w_vel_grav;
    vel_t                    w_vel_next;
    logic                    w_step;
    logic                    w_go_idle;
    coord_t                  w_x1;
    coord_t                  w_x2;
    coord_t                  w_x3;

    // Bird Y after one frame, as an 11-bit two's-complement sum.
    assign w_y_sum   = {1'b0, r_y} + {{(X_W + 1 - VEL_W){r_vel[VEL_W-1]}}, r_vel};
    assign w_y_neg   = w_y_sum[X_W];
    assign w_y_floor = ~w_y_neg & (w_y_sum >= L_FLOOR_Y11);
    assign w_vel_grav = (VEL_W + 1)'(r_vel) + (VEL_W + 1)'(GRAVITY);

    // Tubes move only on a PLAY tick that is not pre-empted by a collision.
    assign w_step    = (r_state == ST_PLAY) & bus.frame_tick & ~bus.loose;
    assign w_go_idle = (r_state == ST_DEAD) & r_flap_edge & (r_dead_cnt >= L_DEAD_HOLD);

    // Per-tick bird update: clamp at the ceiling (velocity zeroed there,
    // overriding any flap) and at the floor, else flap or apply capped gravity.
    always_comb begin
        w_y_next   = w_y_sum[X_W-1:0];
        w_vel_next = r_vel;
        if (w_y_neg) begin
            w_y_next   = {X_W{1'b0}};
            w_vel_next = '0;
        end else begin
            if (w_y_floor) begin
                w_y_next = L_FLOOR_Y;
            end else begin
                w_y_next = w_y_sum[X_W-1:0];
            end
            if (r_pend | r_flap_edge) begin
                w_vel_next = L_FLAP_VEL;
            end else if (w_vel_grav > L_VEL_MAX7) begin
                w_vel_next = L_VEL_MAX7[VEL_W-1:0];
            end else begin
                w_vel_next = w_vel_grav[VEL_W-1:0];
            end
        end
    end

    // Game FSM with bird state, flap edge detection and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_y         <= L_BIRD_Y0;
            r_vel       <= '0;
            r_pend      <= 1'b0;
            r_flap_q    <= 1'b0;
            r_flap_edge <= 1'b0;
            r_dead_cnt  <= 8'd0;
            r_playing   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_flap_q    <= bus.flap;
            r_flap_edge <= bus.flap & ~r_flap_q;
            case (r_state)
                ST_IDLE: begin
                    r_y        <= L_BIRD_Y0;
                    r_vel      <= '0;
                    r_pend     <= 1'b0;
                    r_dead_cnt <= 8'd0;
                    if (r_flap_edge) begin
                        r_state   <= ST_PLAY;
                        r_playing <= 1'b1;
                    end else begin
                        r_state   <= ST_IDLE;
                        r_playing <= 1'b0;
                    end
                    r_game_over <= 1'b0;
                end
                ST_PLAY: begin
                    if (bus.loose) begin
                        r_state     <= ST_DEAD;
                        r_playing   <= 1'b0;
                        r_game_over <= 1'b1;
                        r_dead_cnt  <= 8'd0;
                    end else if (bus.frame_tick) begin
                        r_y    <= w_y_next;
                        r_vel  <= w_vel_next;
                        r_pend <= 1'b0;
                        if (w_y_floor) begin
                            r_state     <= ST_DEAD;
                            r_playing   <= 1'b0;
                            r_game_over <= 1'b1;
                            r_dead_cnt  <= 8'd0;
                        end else begin
                            r_state <= ST_PLAY;
                        end
                    end else if (r_flap_edge) begin
                        r_pend <= 1'b1;
                    end else begin
                        r_pend <= r_pend;
                    end
                end
                ST_DEAD: begin
                    if (w_go_idle) begin
                        r_state     <= ST_IDLE;
                        r_y         <= L_BIRD_Y0;
                        r_vel       <= '0;
                        r_pend      <= 1'b0;
                        r_dead_cnt  <= 8'd0;
                        r_playing   <= 1'b0;
                        r_game_over <= 1'b0;
                    end else if (bus.frame_tick && (r_dead_cnt < L_DEAD_HOLD)) begin
                        r_dead_cnt <= r_dead_cnt + 8'd1;
                    end else begin
                        r_dead_cnt <= r_dead_cnt;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_playing   <= 1'b0;
                    r_game_over <= 1'b0;
                end
            endcase
        end
    end

`ifdef FLAPPY_SCORE_EN
    logic [2:0]  w_wrapped;
    logic [1:0]  w_wrap_cnt;
    score_t      r_score;

    assign w_wrap_cnt = {1'b0, w_wrapped[0]} + {1'b0, w_wrapped[1]} + {1'b0, w_wrapped[2]};

    // Score: add this tick's wrap count (saturating), clear on return to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_score <= '0;
        end else if (w_go_idle) begin
            r_score <= '0;
        end else if (w_step) begin
            r_score <= score_sat_add(r_score, w_wrap_cnt);
        end else begin
            r_score <= r_score;
        end
    end

    assign bus.score = r_score;
`else
    assign bus.score = 8'd0;
`endif

    tube_scroller #(
        .X0    (TUBE_X0),
        .SPEED (TUBE_SPEED),
        .SPAN  (3 * TUBE_GAP)
    ) u_tube1 (
        .clk       (clk),
        .reset     (reset),
        .i_step    (w_step),
        .i_load    (w_go_idle),
        .o_x       (w_x1)
`ifdef FLAPPY_SCORE_EN
        ,
        .o_wrapped (w_wrapped[0])
`endif
    );

    tube_scroller #(
        .X0    (TUBE_X0 + TUBE_GAP),
        .SPEED (TUBE_SPEED),
        .SPAN  (3 * TUBE_GAP)
    ) u_tube2 (
        .clk       (clk),
        .reset     (reset),
        .i_step    (w_step),
        .i_load    (w_go_idle),
        .o_x       (w_x2)
`ifdef FLAPPY_SCORE_EN
        ,
        .o_wrapped (w_wrapped[1])
`endif
    );

    tube_scroller #(
        .X0    (TUBE_X0 + 2 * TUBE_GAP),
        .SPEED (TUBE_SPEED),
        .SPAN  (3 * TUBE_GAP)
    ) u_tube3 (
        .clk       (clk),
        .reset     (reset),
        .i_step    (w_step),
        .i_load    (w_go_idle),
        .o_x       (w_x3)
`ifdef FLAPPY_SCORE_EN
        ,
        .o_wrapped (w_wrapped[2])
`endif
    );

    assign bus.posX_tube1 = w_x1;
    assign bus.posX_tube2 = w_x2;
    assign bus.posX_tube3 = w_x3;
    assign bus.pos_y_bird = r_y;
    assign bus.playing    = r_playing;
    assign bus.game_over  = r_game_over;

endmodule

// File: doc/flappy_game_ctrl.md
# flappy_game_ctrl

Game-state controller that produces the world coordinates consumed by the pixel colour decoder. It owns the bird's vertical position and velocity, scrolls the three tubes leftward, and reacts to the decoder's collision flag (`loose`). It sits between the player button and the colour decoder, and is stepped once per video frame by a tick from the VGA timing block.

## Interface
Parameters:
- `TUBE_SPEED`, 2: pixels each tube moves left per frame.
- `TUBE_X0`, 400: reset X position of tube 1. Tube 2 resets to `TUBE_X0+TUBE_GAP`, tube 3 to `TUBE_X0+2*TUBE_GAP`.
- `TUBE_GAP`, 240: X spacing between tubes. The wrap span is `3*TUBE_GAP` = 720.
- `BIRD_Y0`, 200: bird Y position at reset and in IDLE.
- `FLOOR_Y`, 455: maximum bird Y (480 − 25).
- `GRAVITY`, 1: velocity increment per frame.
- `VEL_MAX`, 10: downward velocity cap.
- `FLAP_VEL`, −8: velocity loaded on a flap (signed).
- `DEAD_HOLD`, 30: frames spent in DEAD before a flap is accepted.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `frame_tick`, in, 1: one-cycle pulse, once per frame.
- `flap`, in, 1: debounced button level; only rising edges are used.
- `loose`, in, 1: collision flag from the colour decoder.
- `posX_tube1`, `posX_tube2`, `posX_tube3`, out, 10 each: tube X positions.
- `pos_y_bird`, out, 10: bird top Y position.
- `playing`, out, 1: high while in PLAY.
- `game_over`, out, 1: high while in DEAD.
- `score`, out, 8: number of tubes passed, saturating.

## Operation
- The state machine has three states: IDLE, PLAY and DEAD.
- **IDLE**
  - Bird is held at `BIRD_Y0`; velocity is 0.
  - Tubes are held at their reset X positions; score is 0.
  - A flap edge moves to PLAY.
- **PLAY**, on each `frame_tick`:
  - Bird Y: `y_new = y + vel`, computed as signed 11-bit.
  - If `y_new < 0`: y becomes 0 and vel becomes 0.
  - If `y_new >= FLOOR_Y`: y becomes `FLOOR_Y` and the FSM moves to DEAD.
  - Otherwise, y becomes `y_new`.
  - Velocity: if a flap is pending, vel becomes `FLAP_VEL`; otherwise vel becomes `min(vel+GRAVITY, VEL_MAX)`. The pending flag is then cleared.
  - Each tube: if `posX < TUBE_SPEED`, `posX <= posX + 720 - TUBE_SPEED` (wrap, preserving spacing) and score increments, saturating at 255. Otherwise, `posX <= posX - TUBE_SPEED`.
  - If more than one tube wraps on the same tick, score adds the number of wraps.
- **PLAY**, on any cycle: `loose` high moves to DEAD on the next edge.
- **Flap edge detection:**
  - `flap` is registered, and an edge is `flap & ~flap_q`.
  - In PLAY, an edge sets the pending flag; several edges within one frame count as one.
  - A flap edge on the same cycle as `frame_tick` is applied on that tick.
- **DEAD**
  - Positions, velocity and score are frozen.
  - A frame counter counts ticks up to `DEAD_HOLD`.
  - A flap edge after `DEAD_HOLD` ticks moves to IDLE and reloads all positions; score is cleared on entry to IDLE.
- **Priority:** `loose` or a floor hit beats a simultaneous tick update. The tick update that caused the floor hit is still committed.

## Timing
- All outputs are registered. Updates caused by a tick are visible on the cycle after the `frame_tick` edge.
- Reset values:
  - State IDLE; vel 0.
  - `posX_tube1`/`posX_tube2`/`posX_tube3` = 400/640/880.
  - `pos_y_bird` = 200.
  - `score` = 0, `playing` = 0, `game_over` = 0.
- Reset is asserted asynchronously. Any state, including mid-PLAY, returns to the reset values immediately.
- Latency from `loose` to `game_over`: 1 cycle.
- Latency from a flap edge in IDLE to `playing`: 2 cycles (edge register, then state register).

## Configuration
- `FLAPPY_SCORE_EN`:
  - When defined: the score counter and wrap counting are built.
  - When undefined: `score` is tied to 0 and no counter logic exists. The port remains, so the interface is unchanged.

## Structure
- Shared package `flappy_pkg`:
  - Screen constants: 640, 480, bird size 25, `FLOOR_Y`.
  - State enum `game_state_t` (IDLE/PLAY/DEAD).
  - Default tube spacing.
- Sub-module `tube_scroller`:
  - One 10-bit X register with reset value, step and wrap logic.
  - Emits a one-cycle `wrapped` pulse.
  - Instantiated three times.

## Test plan
- Reset, then release → `posX_tube1`/`posX_tube2`/`posX_tube3` = 400/640/880, `pos_y_bird` = 200, `playing` = 0. Ticks without a flap change nothing.
- Flap in IDLE, then 3 ticks with no further flap → `playing` = 1; `pos_y_bird` goes 200, 201, 203; tube 1 goes 398, 396, 394.
- Flap edge coincident with a tick at y=250, vel=5 → y = 255 and vel = −8. Next tick → y = 247.
- Force tube 1 to 1 with speed 2 during PLAY → next tick gives posX 719 and score +1. With `FLAPPY_SCORE_EN` undefined, score stays 0.
- Pulse `loose` for one cycle in PLAY → `game_over` = 1 next cycle, positions frozen. Flap before 30 ticks is ignored. Flap after 30 ticks → IDLE, reset positions, score 0.
- Let the bird fall to the floor → `pos_y_bird` = 455 and DEAD. Assert `reset` mid-PLAY → all outputs return to their reset values without a clock edge.
